cpu_matrix_core: RTL and testbench

Parametrised successor to the 8-register LED-matrix CPU. It fetches 16-bit instructions from an external ROM through a multi-cycle fetch FSM with configurable ROM latency, and executes an extended ISA with carry and zero flags. It also scans registers r0..r7 onto an 8-row LED matrix using its own internal prescaler. It sits between the instruction ROM and the board LED/matrix/button pins.

---
 rtl/cpu_matrix_core_if.sv | 17 +
 rtl/cpu_matrix_core.sv | 128 ++++++++++++
 tb/tb_cpu_matrix_core.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_matrix_core_if.sv
// cpu_matrix_core_if: ROM fetch bus and board pins of cpu_matrix_core
// master (core): drives adr, led, row, col, halted; receives dout, btn
// slave (board/ROM side): the mirror image
interface cpu_matrix_core_if #(
  parameter int DW = 8,
  parameter int AW = 11
);
  logic [AW-1:0] adr;
  logic [15:0] dout;
  logic [3:0] btn;
  logic [3:0] led;
  logic [DW-1:0] row;
  logic [7:0] col;
  logic halted;
  modport master (output adr, led, row, col, halted, input dout, btn);
  modport slave (input adr, led, row, col, halted, output dout, btn);
endinterface

// File: rtl/cpu_matrix_core.sv
// cpu_matrix_core: multi-cycle 16-bit-ISA CPU with carry/zero flags driving an 8-row LED matrix
// Ports: clk; reset (async, active-low); bus (cpu_matrix_core_if.master):
//   adr = pc, dout = ROM word, btn -> r5, led = r6[3:0],
//   row = bit-reversed r[scan], col = active-low one-hot scan, halted after HLT.
// Optional: define CPU_STACK_EN to build the CALL/RET return stack.
module cpu_matrix_core #(
  parameter int DW = 8,
  parameter int AW = 11,
  parameter int ROM_LAT = 1,
  parameter int SCAN_DIV = 13,
  parameter int STACK_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  cpu_matrix_core_if.master bus
);
  localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, HALT = 2'd2;
  localparam int CW = ROM_LAT > 1 ? $clog2(ROM_LAT) : 1;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] pc, pc_nx, pc_inc, tgt;
  logic [15:0] ir;
  logic [4:0] op;
  logic [2:0] rd, rs, scan;
  logic [DW-1:0] r [8];
  logic [DW-1:0] a, b, res;
  logic c, z, c_nx, wr, fl, tk, halted;
  logic [SCAN_DIV-1:0] presc;
  assign op = ir[15:11];
  assign rd = ir[10:8];
  assign rs = ir[2:0];
  assign tgt = ir[AW-1:0];
  assign a = r[rd];
  assign b = r[rs];
  assign pc_inc = pc + AW'(1);
  // wr: result lands in rd; fl: flags updated from res/c_nx
  always_comb begin
    res = '0;
    wr = 1'b0;
    fl = 1'b0;
    c_nx = c;
    case (op)
      5'b00001: {wr, res} = {1'b1, b};
      5'b00010: begin wr = 1'b1; res[7:0] = ir[7:0]; end
      5'b00011: {wr, fl, c_nx, res} = {2'b11, {1'b0, a} + {1'b0, b}};
      5'b00100: {wr, fl, c_nx, res} = {2'b11, {1'b0, a} - {1'b0, b}};
      5'b00101: {wr, fl, c_nx, res} = {3'b110, a & b};
      5'b00110: {wr, fl, c_nx, res} = {3'b110, a | b};
      5'b00111: {wr, fl, c_nx, res} = {3'b110, a ^ b};
      5'b01000: {wr, fl, c_nx, res} = {2'b11, {1'b0, a} + (DW+1)'(1)};
      5'b01001: {wr, fl, res} = {2'b11, ~a};
      5'b01010: {wr, fl, c_nx, res} = {2'b11, a[0], a[0], a[DW-1:1]};
      5'b01011: {wr, fl, c_nx, res} = {2'b11, a[DW-1], a[DW-2:0], a[DW-1]};
      default: ;
    endcase
  end
  assign tk = op == 5'b10000 || (op == 5'b10001 && !c) || (op == 5'b10010 && c) ||
              (op == 5'b10011 && z) || (op == 5'b10100 && !z);
`ifdef CPU_STACK_EN
  localparam int SW = $clog2(STACK_DEPTH + 1);
  logic [AW-1:0] stk [2**SW];
  logic [SW-1:0] sp;
  logic push, pop;
  // a CALL on a full stack still jumps; only the push is lost
  assign push = state == EXEC && op == 5'b11000 && sp != SW'(STACK_DEPTH);
  assign pop = state == EXEC && op == 5'b11001 && sp != '0;
  assign pc_nx = (tk || op == 5'b11000) ? tgt : pop ? stk[sp - SW'(1)] : pc_inc;
  always_ff @(posedge clk or negedge reset)
    if (!reset) sp <= '0;
    else sp <= push ? sp + SW'(1) : pop ? sp - SW'(1) : sp;
  always_ff @(posedge clk)
    if (push) stk[sp] <= pc_inc;
`else
  assign pc_nx = tk ? tgt : pc_inc;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= FETCH;
      cnt <= '0;
      pc <= '0;
      ir <= '0;
      c <= 1'b0;
      z <= 1'b0;
      halted <= 1'b0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      case (state)
        FETCH:
          if (cnt == CW'(ROM_LAT - 1)) begin
            ir <= bus.dout;
            cnt <= '0;
            state <= EXEC;
          end else cnt <= cnt + CW'(1);
        EXEC: begin
          if (op == 5'b11111) begin
            halted <= 1'b1;
            state <= HALT;
          end else begin
            pc <= pc_nx;
            state <= FETCH;
          end
          if (wr && rd != 3'd5) r[rd] <= res;
          if (fl) begin
            c <= c_nx;
            z <= res == '0;
          end
        end
        default: ;
      endcase
      r[5] <= {{(DW-4){1'b0}}, bus.btn};
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      presc <= '0;
      scan <= '0;
    end else begin
      presc <= presc + SCAN_DIV'(1);
      if (&presc) scan <= scan + 3'd1;
    end
  always_comb begin
    bus.row = '0;
    for (int k = 0; k < DW; k++) bus.row[k] = r[scan][DW-1-k];
  end
  assign bus.col = ~(8'd1 << scan);
  assign bus.adr = pc;
  assign bus.led = r[6][3:0];
  assign bus.halted = halted;
endmodule

// File: tb/tb_cpu_matrix_core.sv
// tb_cpu_matrix_core: scoreboard bench running small ROM programs and reading registers back through the matrix scan
module tb_cpu_matrix_core;
  typedef struct {int idx; logic [7:0] val;} reg_exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int fails = 0;
  logic [15:0] rom [2048];
  logic [10:0] trace[$];
  logic [10:0] exp_trace[$];
  reg_exp_t exp_regs[$];
  cpu_matrix_core_if #(.DW(8), .AW(11)) bus ();
  cpu_matrix_core #(.DW(8), .AW(11), .ROM_LAT(2), .SCAN_DIV(2), .STACK_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // one-clock registered ROM: data for a new adr is ready by the second fetch clock
  always_ff @(posedge clk) bus.dout <= rom[bus.adr];

  function automatic logic [7:0] rev8(input logic [7:0] x);
    for (int k = 0; k < 8; k++) rev8[k] = x[7-k];
  endfunction

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 16'hF800;
  endtask

  task automatic run_prog(input int max_cyc);
    trace.delete();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    trace.push_back(bus.adr);
    for (int i = 0; i < max_cyc && bus.halted !== 1'b1; i++) begin
      @(negedge clk);
      if (bus.adr !== trace[$]) trace.push_back(bus.adr);
    end
  endtask

  // returns on the first sample of the scan window that shows register idx
  task automatic read_reg(input int idx, output logic [7:0] v, output bit ok);
    logic [7:0] want, prev;
    want = ~(8'd1 << idx);
    ok = 1'b0;
    v = 'x;
    prev = bus.col;
    for (int i = 0; i < 80 && !ok; i++) begin
      @(negedge clk);
      if (prev !== want && bus.col === want) begin
        ok = 1'b1;
        v = rev8(bus.row);
      end
      prev = bus.col;
    end
  endtask

  task automatic test_reset();
    logic [10:0] exp_adr[$];
    logic [10:0] ea;
    clear_rom();
    foreach (rom[i]) rom[i] = 16'h0000;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.adr !== 11'd0) begin fails++; $display("FAIL reset adr: got %h want 0", bus.adr); end
    checks++; if (bus.led !== 4'h0) begin fails++; $display("FAIL reset led: got %h want 0", bus.led); end
    checks++; if (bus.col !== 8'hFE) begin fails++; $display("FAIL reset col: got %h want fe", bus.col); end
    checks++; if (bus.row !== 8'h00) begin fails++; $display("FAIL reset row: got %h want 00", bus.row); end
    checks++; if (bus.halted !== 1'b0) begin fails++; $display("FAIL reset halted: got %b want 0", bus.halted); end
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) exp_adr.push_back(11'(k / 3));
    for (int k = 1; exp_adr.size() > 0; k++) begin
      @(negedge clk);
      ea = exp_adr.pop_front();
      checks++;
      if (bus.adr !== ea) begin fails++; $display("FAIL nop step clk %0d: adr got %0d want %0d", k, bus.adr, ea); end
    end
    #2 reset = 1'b0;
    #1 checks++;
    if (bus.adr !== 11'd0 || bus.col !== 8'hFE) begin
      fails++; $display("FAIL async reset: adr %0d col %h want 0 fe", bus.adr, bus.col);
    end
  endtask

  task automatic test_alu();
    logic [7:0] v; bit ok, bad; reg_exp_t e;
    clear_rom();
    rom[0] = 16'h10F0; rom[1] = 16'h1120; rom[2] = 16'h1801; rom[3] = 16'h9007;
    rom[7] = 16'h8800; rom[8] = 16'hF800;
    exp_trace = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd7, 11'd8};
    exp_regs.push_back('{0, 8'h10});
    exp_regs.push_back('{1, 8'h20});
    run_prog(200);
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL alu halt: got %b want 1", bus.halted); end
    bad = trace.size() != exp_trace.size();
    foreach (exp_trace[i]) if (i >= trace.size() || trace[i] !== exp_trace[i]) bad = 1'b1;
    checks++; if (bad) begin fails++; $display("FAIL alu trace: got %p want %p", trace, exp_trace); end
    while (exp_regs.size() > 0) begin
      e = exp_regs.pop_front();
      read_reg(e.idx, v, ok);
      checks++; if (!ok || v !== e.val) begin fails++; $display("FAIL alu r%0d: got %h want %h", e.idx, v, e.val); end
    end
  endtask

  task automatic test_flags();
    logic [7:0] v; bit ok, bad; reg_exp_t e;
    clear_rom();
    rom[0] = 16'h1281; rom[1] = 16'h5A00; rom[2] = 16'h880A; rom[3] = 16'h1301;
    rom[4] = 16'h2303; rom[5] = 16'h900A; rom[6] = 16'h9809; rom[9] = 16'h0E02;
    rom[10] = 16'hF800;
    exp_trace = '{11'd0, 11'd1, 11'd2, 11'd3, 11'd4, 11'd5, 11'd6, 11'd9, 11'd10};
    exp_regs.push_back('{2, 8'h03});
    exp_regs.push_back('{3, 8'h00});
    exp_regs.push_back('{6, 8'h03});
    run_prog(200);
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL flags halt: got %b want 1", bus.halted); end
    bad = trace.size() != exp_trace.size();
    foreach (exp_trace[i]) if (i >= trace.size() || trace[i] !== exp_trace[i]) bad = 1'b1;
    checks++; if (bad) begin fails++; $display("FAIL flags trace: got %p want %p", trace, exp_trace); end
    checks++; if (bus.led !== 4'h3) begin fails++; $display("FAIL flags led: got %h want 3", bus.led); end
    while (exp_regs.size() > 0) begin
      e = exp_regs.pop_front();
      read_reg(e.idx, v, ok);
      checks++; if (!ok || v !== e.val) begin fails++; $display("FAIL flags r%0d: got %h want %h", e.idx, v, e.val); end
    end
  endtask

  task automatic test_btn();
    logic [7:0] v; bit ok; reg_exp_t e;
    clear_rom();
    rom[0] = 16'h0805; rom[1] = 16'h1555; rom[2] = 16'hF800;
    bus.btn = 4'hA;
    exp_regs.push_back('{0, 8'h0A});
    exp_regs.push_back('{5, 8'h0A});
    run_prog(200);
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL btn halt: got %b want 1", bus.halted); end
    while (exp_regs.size() > 0) begin
      e = exp_regs.pop_front();
      read_reg(e.idx, v, ok);
      checks++; if (!ok || v !== e.val) begin fails++; $display("FAIL btn r%0d: got %h want %h", e.idx, v, e.val); end
    end
    bus.btn = 4'h3;
    @(negedge clk);
    checks++;
    if (bus.col !== 8'hDF || rev8(bus.row) !== 8'h03) begin
      fails++; $display("FAIL btn resample: col %h r5 %h want df 03", bus.col, rev8(bus.row));
    end
    bus.btn = 4'h0;
  endtask

  task automatic test_scan();
    logic [7:0] v; bit ok; logic [10:0] a0;
    clear_rom();
    rom[0] = 16'h1001; rom[1] = 16'hF800;
    run_prog(200);
    checks++; if (bus.halted !== 1'b1 || bus.adr !== 11'd1) begin fails++; $display("FAIL scan halt: halted %b adr %0d want 1 1", bus.halted, bus.adr); end
    a0 = bus.adr;
    read_reg(0, v, ok);
    checks++; if (!ok || bus.row !== 8'h80 || bus.col !== 8'hFE) begin fails++; $display("FAIL scan r0: row %h col %h want 80 fe", bus.row, bus.col); end
    repeat (3) @(negedge clk);
    checks++; if (bus.col !== 8'hFE) begin fails++; $display("FAIL scan hold: col %h want fe", bus.col); end
    @(negedge clk);
    checks++; if (bus.col !== 8'hFD || bus.row !== 8'h00) begin fails++; $display("FAIL scan step: col %h row %h want fd 00", bus.col, bus.row); end
    repeat (28) @(negedge clk);
    checks++; if (bus.col !== 8'hFE || bus.row !== 8'h80) begin fails++; $display("FAIL scan wrap: col %h row %h want fe 80", bus.col, bus.row); end
    checks++; if (bus.adr !== a0 || bus.halted !== 1'b1) begin fails++; $display("FAIL scan frozen: adr %0d halted %b want 1 1", bus.adr, bus.halted); end
  endtask

  task automatic test_wrap();
    logic [7:0] v; bit ok, bad; reg_exp_t e;
    clear_rom();
    rom[0] = 16'h17FF; rom[1] = 16'h9004; rom[2] = 16'h87FF; rom[2047] = 16'h4700;
    rom[4] = 16'hF800;
    exp_trace = '{11'd0, 11'd1, 11'd2, 11'd2047, 11'd0, 11'd1, 11'd4};
    exp_regs.push_back('{7, 8'hFF});
    run_prog(200);
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL wrap halt: got %b want 1", bus.halted); end
    bad = trace.size() != exp_trace.size();
    foreach (exp_trace[i]) if (i >= trace.size() || trace[i] !== exp_trace[i]) bad = 1'b1;
    checks++; if (bad) begin fails++; $display("FAIL wrap trace: got %p want %p", trace, exp_trace); end
    while (exp_regs.size() > 0) begin
      e = exp_regs.pop_front();
      read_reg(e.idx, v, ok);
      checks++; if (!ok || v !== e.val) begin fails++; $display("FAIL wrap r%0d: got %h want %h", e.idx, v, e.val); end
    end
  endtask

  task automatic test_stack();
    bit bad;
    clear_rom();
`ifdef CPU_STACK_EN
    rom[0] = 16'hC00A; rom[10] = 16'hC014; rom[20] = 16'hC01E; rom[30] = 16'hC800;
    rom[11] = 16'hC800; rom[1] = 16'hC800; rom[2] = 16'hF800;
    exp_trace = '{11'd0, 11'd10, 11'd20, 11'd30, 11'd11, 11'd1, 11'd2};
`else
    rom[0] = 16'hC005; rom[1] = 16'hC800; rom[2] = 16'hF800; rom[5] = 16'hF800;
    exp_trace = '{11'd0, 11'd1, 11'd2};
`endif
    run_prog(300);
    checks++; if (bus.halted !== 1'b1) begin fails++; $display("FAIL stack halt: got %b want 1", bus.halted); end
    bad = trace.size() != exp_trace.size();
    foreach (exp_trace[i]) if (i >= trace.size() || trace[i] !== exp_trace[i]) bad = 1'b1;
    checks++; if (bad) begin fails++; $display("FAIL stack trace: got %p want %p", trace, exp_trace); end
`ifdef CPU_STACK_EN
    clear_rom();
    rom[0] = 16'hC800; rom[1] = 16'hF800;
    exp_trace = '{11'd0, 11'd1};
    run_prog(100);
    bad = bus.halted !== 1'b1 || trace.size() != exp_trace.size();
    foreach (exp_trace[i]) if (i >= trace.size() || trace[i] !== exp_trace[i]) bad = 1'b1;
    checks++; if (bad) begin fails++; $display("FAIL ret empty: got %p want %p", trace, exp_trace); end
`endif
  endtask

  initial begin
    bus.btn = 4'h0;
    test_reset();
    test_alu();
    test_flags();
    test_btn();
    test_scan();
    test_wrap();
    test_stack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
